// File: rtl/writeback_stage.sv
// Registered write-back stage: source select, sub-word load alignment/extension, next-PC and retire count.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN; otherwise retire_count_o is tied to zero.
module writeback_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int RWIDTH    = 5,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 hold_i,
  input  logic                 flush_i,
  input  logic [AWIDTH-1:0]    pc_i,
  input  logic [DWIDTH-1:0]    alu_res_i,
  input  logic [DWIDTH-1:0]    memory_data_i,
  input  logic                 brtaken_i,
  input  logic [1:0]           wb_sel_i,
  input  logic [1:0]           ld_size_i,
  input  logic                 ld_unsigned_i,
  input  logic [RWIDTH-1:0]    rd_addr_i,
  input  logic                 rd_wen_i,
  output logic                 wb_valid_o,
  output logic                 rd_wen_o,
  output logic [RWIDTH-1:0]    rd_addr_o,
  output logic [DWIDTH-1:0]    writeback_data_o,
  output logic [AWIDTH-1:0]    next_pc_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);

  logic [1:0]        off;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DWIDTH-1:0] load_data;
  logic [AWIDTH-1:0] pc4;
  logic [AWIDTH-1:0] next_pc;
  logic [DWIDTH-1:0] wb_data;
  logic              wen_next;

  assign ready_o  = !hold_i;
  assign off      = alu_res_i[1:0];
  assign pc4      = pc_i + AWIDTH'(4);
  assign next_pc  = brtaken_i ? {alu_res_i[AWIDTH-1:1], 1'b0} : pc4;
  // x0 is hard-wired zero, so a write to it is dropped here rather than in the register file.
  assign wen_next = valid_i && rd_wen_i && (rd_addr_i != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    byte_lane = memory_data_i[7:0];
    load_data = memory_data_i;
    wb_data   = alu_res_i;
    case (off)
      2'd1:    byte_lane = memory_data_i[15:8];
      2'd2:    byte_lane = memory_data_i[23:16];
      2'd3:    byte_lane = memory_data_i[31:24];
      default: byte_lane = memory_data_i[7:0];
    endcase
    half_lane = off[1] ? memory_data_i[31:16] : memory_data_i[15:0];
    case (ld_size_i)
      2'd0: load_data = ld_unsigned_i ? {{(DWIDTH-8){1'b0}}, byte_lane}
                                      : {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
      2'd1: load_data = ld_unsigned_i ? {{(DWIDTH-16){1'b0}}, half_lane}
                                      : {{(DWIDTH-16){half_lane[15]}}, half_lane};
      default: load_data = memory_data_i;
    endcase
    case (wb_sel_i)
      2'd1:    wb_data = load_data;
      2'd2:    wb_data = DWIDTH'(pc4);
      default: wb_data = alu_res_i;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every output register is cleared on reset; the data regs are observable outputs, not scratch storage.
      wb_valid_o       <= 1'b0;
      rd_wen_o         <= 1'b0;
      rd_addr_o        <= '0;
      writeback_data_o <= '0;
      next_pc_o        <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      rd_wen_o   <= 1'b0;
    end else if (!hold_i) begin
      wb_valid_o <= valid_i;
      rd_wen_o   <= wen_next;
      if (valid_i) begin
        rd_addr_o        <= rd_addr_i;
        writeback_data_o <= wb_data;
        next_pc_o        <= next_pc;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the edge where its bundle leaves the stage unheld and unflushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count_o <= '0;
    end else if (wb_valid_o && !hold_i && !flush_i) begin
      retire_count_o <= retire_count_o + CNT_WIDTH'(1);
    end
  end
`else
  assign retire_count_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed corner cases plus randomized traffic against a spec-level model.
// Honors WB_RETIRE_CNT_EN to choose the expected retire counter behaviour.
module tb_writeback_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, hold_i, flush_i, brtaken_i, ld_unsigned_i, rd_wen_i;
  logic          ready_o, wb_valid_o, rd_wen_o;
  logic [AW-1:0] pc_i, next_pc_o;
  logic [DW-1:0] alu_res_i, memory_data_i, writeback_data_o;
  logic [1:0]    wb_sel_i, ld_size_i;
  logic [RW-1:0] rd_addr_i, rd_addr_o;
  logic [CW-1:0] retire_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic          exp_valid, exp_wen;
  logic [RW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_npc;
  int            exp_cnt;

  writeback_stage #(.DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .hold_i(hold_i),
    .flush_i(flush_i), .pc_i(pc_i), .alu_res_i(alu_res_i), .memory_data_i(memory_data_i),
    .brtaken_i(brtaken_i), .wb_sel_i(wb_sel_i), .ld_size_i(ld_size_i),
    .ld_unsigned_i(ld_unsigned_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .wb_valid_o(wb_valid_o), .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o),
    .writeback_data_o(writeback_data_o), .next_pc_o(next_pc_o), .retire_count_o(retire_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_load(input logic [31:0] mem, input logic [31:0] addr,
                                               input int sz, input bit uns);
    int    off;
    int    bits;
    longint val;
    if (sz >= 2) return mem;
    bits = (sz == 0) ? 8 : 16;
    off  = int'(addr % 4);
    if (sz == 1) off = (off / 2) * 2;
    val = longint'((mem >> (8 * off)) % (longint'(1) << bits));
    if (!uns && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
    return val[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] exp_count();
`ifdef WB_RETIRE_CNT_EN
    return CW'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0; exp_wen = 1'b0; exp_addr = '0;
    exp_data  = '0;   exp_npc = '0;   exp_cnt  = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".wb_valid"}, 64'(wb_valid_o), 64'(exp_valid));
    check({tag, ".rd_wen"},   64'(rd_wen_o),   64'(exp_wen));
    check({tag, ".rd_addr"},  64'(rd_addr_o),  64'(exp_addr));
    check({tag, ".data"},     64'(writeback_data_o), 64'(exp_data));
    check({tag, ".next_pc"},  64'(next_pc_o),  64'(exp_npc));
    check({tag, ".retire"},   64'(retire_count_o), 64'(exp_count()));
  endtask

  // One clock of stimulus: drive after a falling edge, update the model, check after the rising edge.
  task automatic step(input string tag, input bit v, input bit h, input bit f,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                      input bit br, input int sel, input int sz, input bit uns,
                      input int rd, input bit wen);
    logic [31:0] pc4;
    valid_i = v; hold_i = h; flush_i = f; pc_i = pc; alu_res_i = alu; memory_data_i = mem;
    brtaken_i = br; wb_sel_i = 2'(sel); ld_size_i = 2'(sz); ld_unsigned_i = uns;
    rd_addr_i = RW'(rd); rd_wen_i = wen;
    #1;
    check({tag, ".ready"}, 64'(ready_o), 64'(!h));
    if (exp_valid && !h && !f) exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (f) begin
      exp_valid = 1'b0;
      exp_wen   = 1'b0;
    end else if (!h) begin
      exp_valid = v;
      exp_wen   = v && wen && (rd != 0);
      if (v) begin
        pc4      = pc + 32'd4;
        exp_addr = RW'(rd);
        exp_npc  = br ? (alu & ~32'd1) : pc4;
        if (sel == 1)      exp_data = model_load(mem, alu, sz, uns);
        else if (sel == 2) exp_data = pc4;
        else               exp_data = alu;
      end
    end
    @(posedge clk);
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    valid_i = 0; hold_i = 0; flush_i = 0; pc_i = '0; alu_res_i = '0; memory_data_i = '0;
    brtaken_i = 0; wb_sel_i = '0; ld_size_i = '0; ld_unsigned_i = 0; rd_addr_i = '0; rd_wen_i = 0;
    model_reset();
    #3;
    compare_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Sub-word loads, including the sign/zero extension cases.
    step("ld_b_s", 1, 0, 0, 32'h100, 32'h1003, 32'h80FF_1234, 0, 1, 0, 0, 3, 1);
    check("ld_b_s.lit", 64'(writeback_data_o), 64'h0000_0000_FFFF_FF80);
    step("ld_b_u", 1, 0, 0, 32'h104, 32'h1003, 32'h80FF_1234, 0, 1, 0, 1, 3, 1);
    check("ld_b_u.lit", 64'(writeback_data_o), 64'h0000_0000_0000_0080);
    step("ld_h_s", 1, 0, 0, 32'h108, 32'h1002, 32'h80FF_1234, 0, 1, 1, 0, 4, 1);
    check("ld_h_s.lit", 64'(writeback_data_o), 64'h0000_0000_FFFF_80FF);
    step("ld_h_o3", 1, 0, 0, 32'h10C, 32'h1003, 32'h80FF_1234, 0, 1, 1, 1, 4, 1);
    step("ld_w", 1, 0, 0, 32'h110, 32'h1003, 32'h80FF_1234, 0, 1, 2, 0, 4, 1);

    // PC+4 wraparound and branch target bit-0 clearing.
    step("pc_wrap", 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 2, 0, 0, 1, 1);
    check("pc_wrap.data", 64'(writeback_data_o), 64'h0);
    check("pc_wrap.npc", 64'(next_pc_o), 64'h0);
    step("br", 1, 0, 0, 32'hFFFF_FFFC, 32'h2001, 32'h0, 1, 2, 0, 0, 1, 1);
    check("br.npc", 64'(next_pc_o), 64'h2000);

    // x0 destination never written.
    step("x0", 1, 0, 0, 32'h200, 32'h55, 32'h0, 0, 0, 0, 0, 0, 1);
    check("x0.valid", 64'(wb_valid_o), 64'h1);
    check("x0.wen", 64'(rd_wen_o), 64'h0);

    // Hold freezes everything, then flush beats hold.
    step("pre_hold", 1, 0, 0, 32'h300, 32'hABCD, 32'h0, 0, 0, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 1, 1, 0, 32'h400 + 32'(i), 32'h9999, 32'h0, 1, 1, 0, 0, 9, 1);
    step("flush_hold", 1, 1, 1, 32'h500, 32'h1, 32'h0, 0, 0, 0, 0, 3, 1);
    check("flush_hold.valid", 64'(wb_valid_o), 64'h0);
    step("flush", 1, 0, 1, 32'h504, 32'h2, 32'h0, 0, 0, 0, 0, 3, 1);
    idle("idle0");

    // Reset asserted mid-hold with a live bundle: outputs clear immediately.
    step("pre_rst", 1, 0, 0, 32'h600, 32'h77, 32'h0, 0, 0, 0, 0, 5, 1);
    hold_i = 1; valid_i = 1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("mid_rst");
    check("mid_rst.ready", 64'(ready_o), 64'h0);
    @(negedge clk);
    hold_i = 0;
    #1;
    check("rst.ready", 64'(ready_o), 64'h1);
    reset = 1'b1;

    // Back-to-back bundles: 17 retirements wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++)
      step($sformatf("b2b%0d", i), 1, 0, 0, 32'h700 + 32'(4 * i), 32'(i), 32'h0, 0, 0, 0, 0, 1 + i % 31, 1);
    idle("b2b_end");
`ifdef WB_RETIRE_CNT_EN
    check("retire_wrap", 64'(retire_count_o), 64'h1);
`else
    check("retire_off", 64'(retire_count_o), 64'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
